// File: rtl/date_sequencer.sv
// Calendar date controller: BCD day/month/year registers advanced once per day_tick,
// with validated full-date load and clamping of the day against the month length.
module date_sequencer #(
  parameter logic [3:0] RST_YEAR_THOUSAND = 4'd2,
  parameter logic [3:0] RST_YEAR_HUNDERED = 4'd0,
  parameter logic [3:0] RST_YEAR_TEN      = 4'd0,
  parameter logic [3:0] RST_YEAR_UNIT     = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       day_tick,
  input  logic       load,
  input  logic [3:0] ld_day_ten,
  input  logic [3:0] ld_day_unit,
  input  logic [3:0] ld_month_ten,
  input  logic [3:0] ld_month_unit,
  input  logic [3:0] ld_year_thousand,
  input  logic [3:0] ld_year_hundered,
  input  logic [3:0] ld_year_ten,
  input  logic [3:0] ld_year_unit,
  input  logic [4:0] max_days,
  output logic [3:0] day_ten,
  output logic [3:0] day_unit,
  output logic [3:0] month_ten,
  output logic [3:0] month_unit,
  output logic [3:0] year_thousand,
  output logic [3:0] year_hundered,
  output logic [3:0] year_ten,
  output logic [3:0] year_unit,
  output logic       busy,
  output logic       year_wrap,
  output logic       load_err,
  output logic       tick_overrun
);

  typedef enum logic [2:0] {S_IDLE, S_DAY, S_MONTH, S_YEAR, S_CLAMP} state_t;

  state_t     state_q, state_d;
  logic [3:0] day_ten_q, day_ten_d, day_unit_q, day_unit_d;
  logic [3:0] month_ten_q, month_ten_d, month_unit_q, month_unit_d;
  logic [3:0] year_th_q, year_th_d, year_hu_q, year_hu_d;
  logic [3:0] year_te_q, year_te_d, year_un_q, year_un_d;
  logic       pending_q, pending_d, overrun_q, overrun_d;
  logic       year_wrap_q, year_wrap_d, load_err_q, load_err_d, busy_q, busy_d;
  logic [7:0] day_bin_s, ld_day_bin_s, ld_month_bin_s;
  logic       ld_valid_s;

  // Converts a day count of at most 31 into two BCD digits {ten, unit}.
  function automatic logic [7:0] bin5_to_bcd(input logic [4:0] b);
    logic [4:0] r;
    if (b >= 5'd30) begin
      r = b - 5'd30;
      return {4'd3, r[3:0]};
    end else if (b >= 5'd20) begin
      r = b - 5'd20;
      return {4'd2, r[3:0]};
    end else if (b >= 5'd10) begin
      r = b - 5'd10;
      return {4'd1, r[3:0]};
    end else begin
      return {4'd0, b[3:0]};
    end
  endfunction

  assign day_bin_s      = {4'd0, day_ten_q} * 8'd10 + {4'd0, day_unit_q};
  assign ld_day_bin_s   = {4'd0, ld_day_ten} * 8'd10 + {4'd0, ld_day_unit};
  assign ld_month_bin_s = {4'd0, ld_month_ten} * 8'd10 + {4'd0, ld_month_unit};
  assign ld_valid_s = (ld_day_ten <= 4'd9) && (ld_day_unit <= 4'd9) &&
                      (ld_month_ten <= 4'd9) && (ld_month_unit <= 4'd9) &&
                      (ld_year_thousand <= 4'd9) && (ld_year_hundered <= 4'd9) &&
                      (ld_year_ten <= 4'd9) && (ld_year_unit <= 4'd9) &&
                      (ld_month_bin_s >= 8'd1) && (ld_month_bin_s <= 8'd12) &&
                      (ld_day_bin_s != 8'd0);

  // Next-state and next-date computation.
  always_comb begin
    state_d      = state_q;
    day_ten_d    = day_ten_q;
    day_unit_d   = day_unit_q;
    month_ten_d  = month_ten_q;
    month_unit_d = month_unit_q;
    year_th_d    = year_th_q;
    year_hu_d    = year_hu_q;
    year_te_d    = year_te_q;
    year_un_d    = year_un_q;
    pending_d    = pending_q;
    overrun_d    = overrun_q;
    year_wrap_d  = 1'b0;
    load_err_d   = 1'b0;

    // While sequencing, one tick can wait in pending; a second one is lost.
    if (state_q != S_IDLE) begin
      if (day_tick) begin
        if (pending_q) overrun_d = 1'b1;
        else           pending_d = 1'b1;
      end else begin
        pending_d = pending_q;
      end
      load_err_d = load;
    end else begin
      load_err_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (load) begin
          if (ld_valid_s) begin
            day_ten_d    = ld_day_ten;
            day_unit_d   = ld_day_unit;
            month_ten_d  = ld_month_ten;
            month_unit_d = ld_month_unit;
            year_th_d    = ld_year_thousand;
            year_hu_d    = ld_year_hundered;
            year_te_d    = ld_year_ten;
            year_un_d    = ld_year_unit;
            overrun_d    = 1'b0;
            pending_d    = day_tick;
            state_d      = S_CLAMP;
          end else begin
            load_err_d = 1'b1;
            if (day_tick) begin
              if (pending_q) overrun_d = 1'b1;
              else           pending_d = 1'b1;
            end else begin
              pending_d = pending_q;
            end
          end
        end else if (day_tick || pending_q) begin
          pending_d = day_tick && pending_q;
          state_d   = S_DAY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DAY: begin
        if (day_bin_s < {3'd0, max_days}) begin
          if (day_unit_q == 4'd9) begin
            day_unit_d = 4'd0;
            day_ten_d  = day_ten_q + 4'd1;
          end else begin
            day_unit_d = day_unit_q + 4'd1;
          end
          state_d = S_IDLE;
        end else begin
          day_ten_d  = 4'd0;
          day_unit_d = 4'd1;
          state_d    = S_MONTH;
        end
      end
      S_MONTH: begin
        if ((month_ten_q == 4'd1) && (month_unit_q == 4'd2)) begin
          month_ten_d  = 4'd0;
          month_unit_d = 4'd1;
          state_d      = S_YEAR;
        end else if (month_unit_q == 4'd9) begin
          month_ten_d  = month_ten_q + 4'd1;
          month_unit_d = 4'd0;
          state_d      = S_IDLE;
        end else begin
          month_unit_d = month_unit_q + 4'd1;
          state_d      = S_IDLE;
        end
      end
      S_YEAR: begin
        // Ripple carry across all four digits; 9999 wraps to 0000.
        if (year_un_q != 4'd9) begin
          year_un_d = year_un_q + 4'd1;
        end else begin
          year_un_d = 4'd0;
          if (year_te_q != 4'd9) begin
            year_te_d = year_te_q + 4'd1;
          end else begin
            year_te_d = 4'd0;
            if (year_hu_q != 4'd9) begin
              year_hu_d = year_hu_q + 4'd1;
            end else begin
              year_hu_d = 4'd0;
              if (year_th_q != 4'd9) begin
                year_th_d = year_th_q + 4'd1;
              end else begin
                year_th_d   = 4'd0;
                year_wrap_d = 1'b1;
              end
            end
          end
        end
        state_d = S_IDLE;
      end
      S_CLAMP: begin
        if (day_bin_s > {3'd0, max_days}) begin
          {day_ten_d, day_unit_d} = bin5_to_bcd(max_days);
        end else begin
          {day_ten_d, day_unit_d} = {day_ten_q, day_unit_q};
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, date and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      day_ten_q    <= 4'd0;
      day_unit_q   <= 4'd1;
      month_ten_q  <= 4'd0;
      month_unit_q <= 4'd1;
      year_th_q    <= RST_YEAR_THOUSAND;
      year_hu_q    <= RST_YEAR_HUNDERED;
      year_te_q    <= RST_YEAR_TEN;
      year_un_q    <= RST_YEAR_UNIT;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      year_wrap_q  <= 1'b0;
      load_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      day_ten_q    <= day_ten_d;
      day_unit_q   <= day_unit_d;
      month_ten_q  <= month_ten_d;
      month_unit_q <= month_unit_d;
      year_th_q    <= year_th_d;
      year_hu_q    <= year_hu_d;
      year_te_q    <= year_te_d;
      year_un_q    <= year_un_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      year_wrap_q  <= year_wrap_d;
      load_err_q   <= load_err_d;
      busy_q       <= busy_d;
    end
  end

  assign day_ten       = day_ten_q;
  assign day_unit      = day_unit_q;
  assign month_ten     = month_ten_q;
  assign month_unit    = month_unit_q;
  assign year_thousand = year_th_q;
  assign year_hundered = year_hu_q;
  assign year_ten      = year_te_q;
  assign year_unit     = year_un_q;
  assign busy          = busy_q;
  assign year_wrap     = year_wrap_q;
  assign load_err      = load_err_q;
  assign tick_overrun  = overrun_q;

endmodule

// File: tb/tb_date_sequencer.sv
// Self-checking bench for date_sequencer; a month-length model stands in for day_of_month
// and a scoreboard queue holds the expected date for each transaction.
module tb_date_sequencer;

  logic       clk, rst, day_tick, load;
  logic [3:0] ld_day_ten, ld_day_unit, ld_month_ten, ld_month_unit;
  logic [3:0] ld_year_thousand, ld_year_hundered, ld_year_ten, ld_year_unit;
  logic [4:0] max_days;
  logic [3:0] day_ten, day_unit, month_ten, month_unit;
  logic [3:0] year_thousand, year_hundered, year_ten, year_unit;
  logic       busy, year_wrap, load_err, tick_overrun;

  typedef struct {
    string       name;
    logic [31:0] date;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mon_i, year_i;
  logic leap_s;

  date_sequencer dut (
    .clk(clk), .rst(rst), .day_tick(day_tick), .load(load),
    .ld_day_ten(ld_day_ten), .ld_day_unit(ld_day_unit),
    .ld_month_ten(ld_month_ten), .ld_month_unit(ld_month_unit),
    .ld_year_thousand(ld_year_thousand), .ld_year_hundered(ld_year_hundered),
    .ld_year_ten(ld_year_ten), .ld_year_unit(ld_year_unit),
    .max_days(max_days),
    .day_ten(day_ten), .day_unit(day_unit), .month_ten(month_ten), .month_unit(month_unit),
    .year_thousand(year_thousand), .year_hundered(year_hundered),
    .year_ten(year_ten), .year_unit(year_unit),
    .busy(busy), .year_wrap(year_wrap), .load_err(load_err), .tick_overrun(tick_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Month-length model, combinational on the DUT's month/year outputs.
  always_comb begin
    mon_i  = int'(month_ten) * 10 + int'(month_unit);
    year_i = int'(year_thousand) * 1000 + int'(year_hundered) * 100 +
             int'(year_ten) * 10 + int'(year_unit);
    leap_s = ((year_i % 4 == 0) && (year_i % 100 != 0)) || (year_i % 400 == 0);
    case (mon_i)
      2:            max_days = leap_s ? 5'd29 : 5'd28;
      4, 6, 9, 11:  max_days = 5'd30;
      default:      max_days = 5'd31;
    endcase
  end

  function automatic logic [31:0] mk(int d, int m, int y);
    return {4'(d / 10), 4'(d % 10), 4'(m / 10), 4'(m % 10),
            4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10)};
  endfunction

  function automatic logic [31:0] cur_date();
    return {day_ten, day_unit, month_ten, month_unit,
            year_thousand, year_hundered, year_ten, year_unit};
  endfunction

  task automatic drive_load(int d, int m, int y);
    logic [31:0] v;
    v = mk(d, m, y);
    @(negedge clk);
    load = 1'b1;
    {ld_day_ten, ld_day_unit, ld_month_ten, ld_month_unit,
     ld_year_thousand, ld_year_hundered, ld_year_ten, ld_year_unit} = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    day_tick = 1'b1;
    @(negedge clk);
    day_tick = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    repeat (3) @(negedge clk);
    while (busy !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: busy=%b still set after cycle budget", busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cur_date() !== mk(1, 1, 2000)) begin
      n_err++;
      $display("FAIL reset_date: got %h expected %h", cur_date(), mk(1, 1, 2000));
    end
    n_cmp++;
    if ({busy, year_wrap, load_err, tick_overrun} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, year_wrap, load_err, tick_overrun});
    end
    rst = 1'b0;
  endtask

  task automatic test_month_rollover();
    int bc;
    drive_load(28, 2, 2025);
    wait_idle();
    sb.push_back('{"feb2025_tick", mk(1, 3, 2025)});
    pulse_tick();
    bc = 0;
    while (busy === 1'b1 && bc < 10) begin
      bc++;
      @(negedge clk);
    end
    n_cmp++;
    if (bc !== 2) begin
      n_err++;
      $display("FAIL busy_cycles: got %0d expected 2", bc);
    end
    e = sb.pop_front();
    n_cmp++;
    if (cur_date() !== e.date) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.name, cur_date(), e.date);
    end
  endtask

  task automatic test_leap();
    drive_load(28, 2, 2024);
    wait_idle();
    sb.push_back('{"leap_29feb", mk(29, 2, 2024)});
    sb.push_back('{"leap_1mar", mk(1, 3, 2024)});
    sb.push_back('{"y2100_1mar", mk(1, 3, 2100)});
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        drive_load(28, 2, 2100);
        wait_idle();
      end
      pulse_tick();
      wait_idle();
      e = sb.pop_front();
      n_cmp++;
      if (cur_date() !== e.date) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, cur_date(), e.date);
      end
    end
  endtask

  task automatic test_year_wrap();
    int wrap_cnt, wrap_at;
    drive_load(31, 12, 9999);
    wait_idle();
    sb.push_back('{"wrap_9999", mk(1, 1, 0)});
    pulse_tick();
    wrap_cnt = 0;
    wrap_at  = 0;
    for (int i = 1; i <= 6; i++) begin
      if (year_wrap === 1'b1) begin
        wrap_cnt++;
        wrap_at = i;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (wrap_cnt !== 1 || wrap_at !== 4) begin
      n_err++;
      $display("FAIL year_wrap_pulse: got %0d pulses at edge +%0d expected 1 at +4", wrap_cnt, wrap_at);
    end
    e = sb.pop_front();
    n_cmp++;
    if (cur_date() !== e.date) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.name, cur_date(), e.date);
    end
    drive_load(19, 9, 2039);
    wait_idle();
    sb.push_back('{"bcd_day_19_20", mk(20, 9, 2039)});
    pulse_tick();
    wait_idle();
    e = sb.pop_front();
    n_cmp++;
    if (cur_date() !== e.date) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.name, cur_date(), e.date);
    end
  endtask

  task automatic test_clamp_and_err();
    drive_load(31, 2, 2100);
    n_cmp++;
    if (cur_date() !== mk(31, 2, 2100) || busy !== 1'b1) begin
      n_err++;
      $display("FAIL load_written: got %h busy=%b expected %h busy=1", cur_date(), busy, mk(31, 2, 2100));
    end
    @(negedge clk);
    n_cmp++;
    if (cur_date() !== mk(28, 2, 2100)) begin
      n_err++;
      $display("FAIL clamp: got %h expected %h", cur_date(), mk(28, 2, 2100));
    end
    drive_load(13, 13, 2025);
    n_cmp++;
    if (load_err !== 1'b1) begin
      n_err++;
      $display("FAIL load_err_bad_month: got %b expected 1", load_err);
    end
    @(negedge clk);
    n_cmp++;
    if (load_err !== 1'b0 || cur_date() !== mk(28, 2, 2100)) begin
      n_err++;
      $display("FAIL bad_load_unchanged: got err=%b %h expected err=0 %h", load_err, cur_date(), mk(28, 2, 2100));
    end
    sb.push_back('{"load_while_busy", mk(1, 3, 2100)});
    pulse_tick();
    drive_load(5, 5, 2025);
    n_cmp++;
    if (load_err !== 1'b1) begin
      n_err++;
      $display("FAIL load_err_busy: got %b expected 1", load_err);
    end
    wait_idle();
    e = sb.pop_front();
    n_cmp++;
    if (cur_date() !== e.date) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.name, cur_date(), e.date);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 2; n <= 3; n++) begin
      drive_load(30, 6, 2030);
      wait_idle();
      sb.push_back('{(n == 2) ? "two_ticks" : "three_ticks", mk(2, 7, 2030)});
      @(negedge clk);
      day_tick = 1'b1;
      repeat (n) @(negedge clk);
      day_tick = 1'b0;
      wait_idle();
      e = sb.pop_front();
      n_cmp++;
      if (cur_date() !== e.date) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", e.name, cur_date(), e.date);
      end
      n_cmp++;
      if (tick_overrun !== (n == 3)) begin
        n_err++;
        $display("FAIL overrun_%0d_ticks: got %b expected %b", n, tick_overrun, n == 3);
      end
    end
    drive_load(1, 1, 2031);
    n_cmp++;
    if (tick_overrun !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_clear: got %b expected 0", tick_overrun);
    end
    wait_idle();
  endtask

  task automatic test_reset_midop();
    drive_load(31, 12, 2049);
    wait_idle();
    pulse_tick();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || cur_date() !== mk(1, 1, 2049)) begin
      n_err++;
      $display("FAIL pre_reset_year_state: got busy=%b %h expected busy=1 %h", busy, cur_date(), mk(1, 1, 2049));
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (cur_date() !== mk(1, 1, 2000) || {busy, year_wrap, load_err, tick_overrun} !== 4'b0000) begin
      n_err++;
      $display("FAIL midop_reset: got %h flags=%b expected %h flags=0000", cur_date(),
               {busy, year_wrap, load_err, tick_overrun}, mk(1, 1, 2000));
    end
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{"after_reset_tick", mk(2, 1, 2000)});
    pulse_tick();
    wait_idle();
    e = sb.pop_front();
    n_cmp++;
    if (cur_date() !== e.date) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", e.name, cur_date(), e.date);
    end
  endtask

  initial begin
    rst = 1'b0;
    day_tick = 1'b0;
    load = 1'b0;
    {ld_day_ten, ld_day_unit, ld_month_ten, ld_month_unit,
     ld_year_thousand, ld_year_hundered, ld_year_ten, ld_year_unit} = 32'h0;
    #1 rst = 1'b1;
    test_reset();
    test_month_rollover();
    test_leap();
    test_year_wrap();
    test_clamp_and_err();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/date_sequencer.md
Name: date_sequencer

Overview:
Calendar date controller for the clock. Holds the BCD day, month and year registers and advances them once per day_tick, which is the midnight rollover from the time-of-day counters. Drives its month/year digits into the existing day_of_month block and uses the returned max_days to decide day rollover and to clamp loaded dates. Also accepts a full-date load from the set-time logic.

Parameters:
RST_YEAR_THOUSAND, 2, reset value of the year thousands digit
RST_YEAR_HUNDERED, 0, reset value of the year hundreds digit
RST_YEAR_TEN, 0, reset value of the year tens digit
RST_YEAR_UNIT, 0, reset value of the year units digit

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
day_tick  in  1  one-cycle pulse: advance date by one day
load  in  1  one-cycle pulse: load the ld_* digits
ld_day_ten, ld_day_unit, ld_month_ten, ld_month_unit  in  4 each  BCD load date
ld_year_thousand, ld_year_hundered, ld_year_ten, ld_year_unit  in  4 each  BCD load year
max_days  in  5  binary days in current month, from day_of_month (combinational on this block's outputs)
day_ten, day_unit, month_ten, month_unit  out  4 each  BCD date
year_thousand, year_hundered, year_ten, year_unit  out  4 each  BCD year; also feed day_of_month
busy  out  1  high when FSM is not in IDLE
year_wrap  out  1  one-cycle pulse on 9999 to 0000 rollover
load_err  out  1  one-cycle pulse when a load is rejected
tick_overrun  out  1  sticky flag: a day_tick was lost

Behaviour:
- Reset is asynchronous and active-high; the single clock is clk.
- Reset values: date 01-01-RST_YEAR; FSM in IDLE; pending tick cleared; busy=0, year_wrap=0, load_err=0, tick_overrun=0.
- Reset asserted mid-operation aborts the sequence and restores all reset values. No partial update survives.
- FSM states: IDLE, DAY, MONTH, YEAR, CLAMP.
- IDLE:
  - load has priority over day_tick and pending.
  - A load is valid only if every digit is at most 9, month is in 01..12, and day is at least 01. A valid load writes all digits, then goes to CLAMP.
  - An invalid load pulses load_err; date and state are unchanged.
  - A valid load clears tick_overrun and the pending tick.
  - Otherwise, day_tick or pending goes to DAY and clears pending.
- DAY:
  - If day (ten*10+unit) < max_days: BCD increment of day (09 to 10, 19 to 20, 29 to 30), then go to IDLE.
  - Else: day=01, then go to MONTH.
- MONTH:
  - If month==12: month=01, then go to YEAR.
  - Else: BCD increment (09 to 10), then go to IDLE.
- YEAR: 4-digit BCD increment with ripple carry in one cycle, then go to IDLE. 9999 becomes 0000 and year_wrap pulses for that cycle.
- CLAMP: if day > max_days, day = max_days converted to BCD (28/29/30/31). Go to IDLE.
- max_days is sampled only in DAY and CLAMP. It is always one cycle behind any month/year register write, and that is correct by construction.
- Latency from a day_tick seen in IDLE at edge N: day-only update visible after edge N+1; month rollover after N+2; year rollover after N+3. busy is high from N+1 until the final state exits.
- day_tick while busy: sets pending. If pending is already set, the tick is dropped and tick_overrun is set (sticky).
- day_tick and load in the same IDLE cycle: the load is taken and the tick is recorded as pending. It is processed after CLAMP.
- load while busy: ignored; pulses load_err.
- Back-to-back ticks spaced at least 4 cycles apart are never lost.

Test Plan:
- Bench instantiates day_of_month to drive max_days.
- Load 28-02-2025, tick -> 01-03-2025 after 2 edges; busy high 2 cycles.
- Load 28-02-2024, tick -> 29-02-2024; tick again -> 01-03-2024. Load 28-02-2100, tick -> 01-03-2100 (2100 is not leap).
- Load 31-12-9999, tick -> 01-01-0000 with a one-cycle year_wrap pulse 3 edges after the tick; load 19-09-2039, tick -> 20-09-2039.
- Load 31-02-2100 -> day clamped to 28 one cycle after load. Load 13-13-2025 -> load_err pulse, date unchanged.
- Two ticks on consecutive cycles starting at 30-06-2030 -> 02-07-2030, no overrun. A third tick while pending -> tick_overrun=1, cleared by the next valid load.
- Assert rst during the YEAR state of the 31-12-2049 rollover -> immediately 01-01-2000, busy=0, flags 0; the next tick -> 02-01-2000.
